// File: rtl/gate_cmd_sequencer.sv
// gate_cmd_sequencer: buffers channel commands in a small FIFO. Each command is
// played out as a contiguous burst of strobe-high cycles to the logic-gate
// controller, with select and operands held stable for the whole burst.
//
// Build option: GATE_SEQ_GAP_EN compiles in a one-cycle GAP state after every
// burst. The downstream enables then never switch channel while asserted.
// Without it, consecutive bursts abut.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on flush and the registered
// occupancy, never on cmd_valid. A full FIFO holds ready low even on a cycle
// that pops.
//
// dbg_state exposes the FSM state encoding for checkers.
module gate_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_chan,
    input  logic [3:0]    cmd_a,
    input  logic [1:0]    cmd_b,
    input  logic [3:0]    cmd_len,
    input  logic          flush,
    output logic          ctl_i,
    output logic          ctl_s1,
    output logic          ctl_s0,
    output logic [3:0]    ctl_a,
    output logic [1:0]    ctl_b,
    output logic          busy,
    output logic          burst_done,
    output logic [CW-1:0] fifo_count,
    output logic [1:0]    dbg_state
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef GATE_SEQ_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1} state_t;
`endif

    // FIFO storage: entry packs {chan[11:10], a[9:6], b[5:4], len[3:0]}
    logic [11:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          empty;
    logic [11:0]   head;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          i_n;
    logic [1:0]    sel_q, sel_n;
    logic [3:0]    a_n;
    logic [1:0]    b_n;
    logic          done_n;
    logic          load;

    assign empty      = (count == '0);
    assign cmd_ready  = ~flush & (count < DEPTH_C);
    assign push       = cmd_valid & cmd_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state == DRIVE) | ~empty;
    assign ctl_s1     = sel_q[1];
    assign ctl_s0     = sel_q[0];
    assign dbg_state  = state;

    // FIFO data write; storage needs no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_chan, cmd_a, cmd_b, cmd_len};
        end
    end

    // FIFO pointers and occupancy; flush wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state, burst counter and registered controller outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ctl_i      <= 1'b0;
            sel_q      <= '0;
            ctl_a      <= '0;
            ctl_b      <= '0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ctl_i      <= i_n;
            sel_q      <= sel_n;
            ctl_a      <= a_n;
            ctl_b      <= b_n;
            burst_done <= done_n;
        end
    end

    // Next state and next output values; outputs default to zero
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        load    = 1'b0;
        i_n     = 1'b0;
        sel_n   = '0;
        a_n     = '0;
        b_n     = '0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) load = 1'b1;
            end
            DRIVE: begin
                if (cnt != 4'd0) begin
                    cnt_n  = cnt - 4'd1;
                    i_n    = 1'b1;
                    sel_n  = sel_q;
                    a_n    = ctl_a;
                    b_n    = ctl_b;
                    done_n = (cnt == 4'd1);
                end else begin
`ifdef GATE_SEQ_GAP_EN
                    state_n = GAP;
`else
                    if (!empty) load = 1'b1;
                    else        state_n = IDLE;
`endif
                end
            end
`ifdef GATE_SEQ_GAP_EN
            GAP: begin
                if (!empty) load = 1'b1;
                else        state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase

        // Start a burst from the FIFO head
        if (load) begin
            pop     = 1'b1;
            state_n = DRIVE;
            cnt_n   = head[3:0];
            i_n     = 1'b1;
            sel_n   = head[11:10];
            a_n     = head[9:6];
            b_n     = head[5:4];
            done_n  = (head[3:0] == 4'd0);
        end

        // Abort overrides any pop or burst completion
        if (flush) begin
            state_n = IDLE;
            pop     = 1'b0;
            cnt_n   = '0;
            i_n     = 1'b0;
            sel_n   = '0;
            a_n     = '0;
            b_n     = '0;
            done_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_cmd_sequencer.sv
// Directed testbench for gate_cmd_sequencer in its default build (no GAP state).
module tb_gate_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_chan;
    logic [3:0] cmd_a;
    logic [1:0] cmd_b;
    logic [3:0] cmd_len;
    logic       flush;
    logic       ctl_i;
    logic       ctl_s1;
    logic       ctl_s0;
    logic [3:0] ctl_a;
    logic [1:0] ctl_b;
    logic       busy;
    logic       burst_done;
    logic [2:0] fifo_count;
    logic [1:0] dbg_state;

    int n_tests;
    int n_fail;

    gate_cmd_sequencer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_len    (cmd_len),
        .flush      (flush),
        .ctl_i      (ctl_i),
        .ctl_s1     (ctl_s1),
        .ctl_s0     (ctl_s0),
        .ctl_a      (ctl_a),
        .ctl_b      (ctl_b),
        .busy       (busy),
        .burst_done (burst_done),
        .fifo_count (fifo_count),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [1:0] ch, input logic [3:0] a, input logic [1:0] b,
                         input logic [3:0] len);
        cmd_valid = 1'b1;
        cmd_chan  = ch;
        cmd_a     = a;
        cmd_b     = b;
        cmd_len   = len;
    endtask

    // Packed view {ctl_i, s1, s0, burst_done}
    function automatic logic [3:0] ctl_view();
        return {ctl_i, ctl_s1, ctl_s0, burst_done};
    endfunction

    int strobes;
    int dones;
    int done_idx;
    int last_idx;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        cmd_valid = 1'b0;
        cmd_chan  = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_len   = '0;

        // Reset state
        #13;
        check("rst_ctl",   {28'd0, ctl_view()}, 32'h0);
        check("rst_ab",    {ctl_a, ctl_b}, 32'h0);
        check("rst_count", fifo_count, 32'd0);
        check("rst_ready", cmd_ready, 32'd1);
        check("rst_busy",  busy, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single command chan=2 a=A b=1 len=2
        offer(2'd2, 4'hA, 2'b01, 4'd2);
        step();
        cmd_valid = 1'b0;
        check("single_t_count", fifo_count, 32'd1);
        check("single_t_ctl",   ctl_i, 32'd0);
        check("single_t_busy",  busy, 32'd1);
        step();
        check("single_t1_ctl", ctl_view(), 4'b1100);
        check("single_t1_ab",  {ctl_a, ctl_b}, {4'hA, 2'b01});
        check("single_t1_cnt", fifo_count, 32'd0);
        step();
        check("single_t2_ctl", ctl_view(), 4'b1100);
        step();
        check("single_t3_ctl", ctl_view(), 4'b1101);
        step();
        check("single_t4_ctl",  ctl_view(), 4'b0000);
        check("single_t4_busy", busy, 32'd0);
        check("single_t4_st",   dbg_state, 32'd0);

        // Fill: long filler burst, then channels 0..3 with len=0 held valid
        offer(2'd3, 4'h1, 2'b00, 4'd5);
        step();                                   // p0: filler pushed
        offer(2'd0, 4'h0, 2'b00, 4'd0);
        step();                                   // p1
        check("fill_p1_ctl", ctl_view(), 4'b1110);
        offer(2'd1, 4'h1, 2'b00, 4'd0);
        step();                                   // p2
        offer(2'd2, 4'h2, 2'b00, 4'd0);
        step();                                   // p3
        offer(2'd3, 4'h3, 2'b00, 4'd0);
        step();                                   // p4: fourth entry
        check("fill_full_count", fifo_count, 32'd4);
        check("fill_full_ready", cmd_ready, 32'd0);
        offer(2'd1, 4'hF, 2'b11, 4'd0);           // not accepted while full
        step();                                   // p5
        check("fill_p5_count", fifo_count, 32'd4);
        step();                                   // p6: filler last cycle
        check("fill_p6_ctl", ctl_view(), 4'b1111);
        step();                                   // p7: pop at full, no push
        cmd_valid = 1'b0;
        check("fill_p7_count", fifo_count, 32'd3);
        check("fill_p7_ctl",   ctl_view(), 4'b1001);
        step();
        check("fill_p8_ctl", ctl_view(), 4'b1011);
        check("fill_p8_a",   ctl_a, 32'h1);
        step();
        check("fill_p9_ctl", ctl_view(), 4'b1101);
        step();
        check("fill_p10_ctl",   ctl_view(), 4'b1111);
        check("fill_p10_count", fifo_count, 32'd0);
        step();
        check("fill_p11_ctl", ctl_view(), 4'b0000);

        // Push coinciding with pop at count=2
        offer(2'd1, 4'h7, 2'b10, 4'd3);
        step();                                   // p0
        offer(2'd0, 4'h4, 2'b00, 4'd0);
        step();                                   // p1: X
        offer(2'd2, 4'h5, 2'b01, 4'd0);
        step();                                   // p2: Y
        cmd_valid = 1'b0;
        step();                                   // p3
        step();                                   // p4
        check("pp_p4_done",  burst_done, 32'd1);
        check("pp_p4_count", fifo_count, 32'd2);
        offer(2'd3, 4'h6, 2'b10, 4'd0);
        step();                                   // p5: Z pushed, X popped
        cmd_valid = 1'b0;
        check("pp_p5_count", fifo_count, 32'd2);
        check("pp_p5_ctl",   ctl_view(), 4'b1001);
        check("pp_p5_a",     ctl_a, 32'h4);
        step();
        check("pp_p6_ctl",   ctl_view(), 4'b1101);
        check("pp_p6_ab",    {ctl_a, ctl_b}, {4'h5, 2'b01});
        step();
        check("pp_p7_ctl",   ctl_view(), 4'b1111);
        check("pp_p7_ab",    {ctl_a, ctl_b}, {4'h6, 2'b10});
        step();
        check("pp_p8_ctl",   ctl_view(), 4'b0000);

        // Flush during len=7 burst with 2 queued
        offer(2'd1, 4'h9, 2'b11, 4'd7);
        step();
        offer(2'd2, 4'h2, 2'b00, 4'd1);
        step();
        offer(2'd3, 4'h3, 2'b00, 4'd1);
        step();
        cmd_valid = 1'b0;
        step();
        check("fl_pre_count", fifo_count, 32'd2);
        check("fl_pre_ctl",   ctl_i, 32'd1);
        flush = 1'b1;
        offer(2'd0, 4'h8, 2'b00, 4'd0);
        #1;
        check("fl_ready", cmd_ready, 32'd0);
        step();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        check("fl_ctl",   ctl_view(), 4'b0000);
        check("fl_ab",    {ctl_a, ctl_b}, 32'h0);
        check("fl_count", fifo_count, 32'd0);
        check("fl_busy",  busy, 32'd0);
        step();
        check("fl_after_count", fifo_count, 32'd0);
        check("fl_after_ctl",   ctl_i, 32'd0);

        // len=15: 16 strobes, one done pulse on the last strobe
        offer(2'd2, 4'h5, 2'b11, 4'd15);
        step();
        cmd_valid = 1'b0;
        strobes  = 0;
        dones    = 0;
        done_idx = -1;
        last_idx = -2;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) check("l15_a", ctl_a, 32'h5);
            if (ctl_i) begin
                strobes++;
                last_idx = k;
            end
            if (burst_done) begin
                dones++;
                done_idx = k;
            end
        end
        check("l15_strobes", strobes, 32'd16);
        check("l15_dones",   dones, 32'd1);
        check("l15_doneidx", done_idx, last_idx);

        // Asynchronous reset mid-burst
        offer(2'd1, 4'hC, 2'b10, 4'd7);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("ar_pre_ctl", ctl_i, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_ctl",   ctl_view(), 4'b0000);
        check("ar_count", fifo_count, 32'd0);
        check("ar_ready", cmd_ready, 32'd1);
        check("ar_state", dbg_state, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ar_after_ctl", ctl_i, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
